usb_fs_line_tx: RTL and testbench

USB_FS_LINE_TX -- requirements
Module: usb_fs_line_tx

---
 rtl/usb_fs_line_tx.sv | 273 +++++++++++++++++++++++++++
 tb/tb_usb_fs_line_tx.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_fs_line_tx.sv
// ---------------------------------------------------------------------------
// usb_fs_line_tx
//
// Full-speed USB line transmitter. Takes a byte stream (first byte is the
// PID) and drives the D+/D- pair: SYNC, NRZI-encoded data with bit stuffing,
// then EOP (SE0, SE0, J).
//
// Parameters
//   BitClks      clk_i cycles per USB bit time (2..16)
//
// Ports
//   clk_i        transmit clock
//   rst_ni       asynchronous active-low reset
//   tx_data_i    byte to send, LSB first
//   tx_valid_i   byte available
//   tx_last_i    tx_data_i is the final byte of the packet
//   tx_ready_o   byte accepted when tx_valid_i & tx_ready_o (combinational)
//   usb_dp_o     D+ drive value (registered)
//   usb_dn_o     D- drive value (registered)
//   usb_oe_o     driver output enable (registered)
//   busy_o       state is not IDLE (registered)
//   underflow_o  one-cycle pulse when a packet is cut short for lack of data
// ---------------------------------------------------------------------------
module usb_fs_line_tx #(
  parameter int unsigned BitClks = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  input  logic       tx_last_i,
  output logic       tx_ready_o,
  output logic       usb_dp_o,
  output logic       usb_dn_o,
  output logic       usb_oe_o,
  output logic       busy_o,
  output logic       underflow_o
);

  localparam int unsigned PhaseW = $clog2(BitClks);

  // Sent LSB first this gives bits 0,0,0,0,0,0,0,1, i.e. line KJKJKJKK.
  localparam logic [7:0] SyncPat = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP_SE0,
    EOP_J
  } state_e;

  state_e              state_q, state_d;
  logic [PhaseW-1:0]   phase_q, phase_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [2:0]          ones_q, ones_d;
  logic                stuff_q, stuff_d;
  logic [7:0]          shift_q, shift_d;
  logic                last_q, last_d;
  logic                line_j_q, line_j_d;
  logic                dp_q, dp_d;
  logic                dn_q, dn_d;
  logic                oe_q, oe_d;
  logic                busy_q, busy_d;
  logic                uf_q, uf_d;

  logic                bit_end;
  logic                cur_bit;
  logic [2:0]          ones_inc;
  logic                stuff_due;
  logic                byte_end;
  logic                send_en;
  logic                send_bit;

  assign bit_end  = (phase_q == PhaseW'(BitClks - 1));
  assign cur_bit  = (state_q == SYNC) ? SyncPat[bit_cnt_q] : shift_q[0];
  assign ones_inc = cur_bit ? (ones_q + 3'd1) : 3'd0;

  // A stuff bit follows the data bit that brings the ones count to six.
  assign stuff_due = (state_q == DATA) && !stuff_q && (ones_inc == 3'd6);

  // Byte boundary: end of the eighth bit, or end of the stuff bit that
  // follows it. This is where the next byte is requested.
  assign byte_end = (state_q == DATA) && bit_end && (bit_cnt_q == 3'd7) && !stuff_due;

  assign tx_ready_o = (state_q == IDLE) ? tx_valid_i : (byte_end && !last_q);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    ones_d    = ones_q;
    stuff_d   = stuff_q;
    shift_d   = shift_q;
    last_d    = last_q;
    line_j_d  = line_j_q;
    uf_d      = 1'b0;
    send_en   = 1'b0;
    send_bit  = 1'b0;
    dp_d      = 1'b1;
    dn_d      = 1'b0;
    oe_d      = 1'b0;

    if (state_q == IDLE) begin
      phase_d = '0;
    end else if (bit_end) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + PhaseW'(1);
    end

    case (state_q)
      IDLE: begin
        line_j_d = 1'b1;
        if (tx_valid_i) begin
          state_d   = SYNC;
          shift_d   = tx_data_i;
          last_d    = tx_last_i;
          bit_cnt_d = 3'd0;
          ones_d    = 3'd0;
          stuff_d   = 1'b0;
          // Line is J before SYNC, so the first SYNC bit is NRZI-coded from J.
          line_j_d  = SyncPat[0];
        end
      end

      SYNC: begin
        if (bit_end) begin
          ones_d  = ones_inc;
          send_en = 1'b1;
          if (bit_cnt_q == 3'd7) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
            send_bit  = shift_q[0];
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            send_bit  = SyncPat[bit_cnt_q + 3'd1];
          end
        end
      end

      DATA: begin
        if (bit_end) begin
          // During a stuff bit the shift register has already advanced.
          if (stuff_q) begin
            ones_d = 3'd0;
          end else begin
            ones_d  = ones_inc;
            shift_d = {1'b0, shift_q[7:1]};
          end
          stuff_d = 1'b0;

          if (stuff_due) begin
            stuff_d  = 1'b1;
            ones_d   = 3'd0;
            send_en  = 1'b1;
            send_bit = 1'b0;
          end else if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            if (last_q) begin
              state_d = EOP_SE0;
            end else if (tx_valid_i) begin
              shift_d  = tx_data_i;
              last_d   = tx_last_i;
              send_en  = 1'b1;
              send_bit = tx_data_i[0];
            end else begin
              uf_d    = 1'b1;
              state_d = EOP_SE0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            send_en   = 1'b1;
            send_bit  = stuff_q ? shift_q[0] : shift_q[1];
          end
        end
      end

      EOP_SE0: begin
        if (bit_end) begin
          if (bit_cnt_q == 3'd1) begin
            state_d   = EOP_J;
            bit_cnt_d = 3'd0;
          end else begin
            bit_cnt_d = 3'd1;
          end
        end
      end

      EOP_J: begin
        if (bit_end) begin
          state_d   = IDLE;
          bit_cnt_d = 3'd0;
          ones_d    = 3'd0;
          stuff_d   = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // NRZI: a 0 toggles the line, a 1 holds it.
    if (send_en) begin
      line_j_d = send_bit ? line_j_q : !line_j_q;
    end

    // Output registers carry the symbol for the state being entered.
    case (state_d)
      SYNC, DATA: begin
        dp_d = line_j_d;
        dn_d = !line_j_d;
        oe_d = 1'b1;
      end
      EOP_SE0: begin
        dp_d = 1'b0;
        dn_d = 1'b0;
        oe_d = 1'b1;
      end
      EOP_J: begin
        dp_d = 1'b1;
        dn_d = 1'b0;
        oe_d = 1'b1;
      end
      default: begin
        dp_d = 1'b1;
        dn_d = 1'b0;
        oe_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      bit_cnt_q <= 3'd0;
      ones_q    <= 3'd0;
      stuff_q   <= 1'b0;
      shift_q   <= 8'd0;
      last_q    <= 1'b0;
      line_j_q  <= 1'b1;
      dp_q      <= 1'b1;
      dn_q      <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      uf_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      ones_q    <= ones_d;
      stuff_q   <= stuff_d;
      shift_q   <= shift_d;
      last_q    <= last_d;
      line_j_q  <= line_j_d;
      dp_q      <= dp_d;
      dn_q      <= dn_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      uf_q      <= uf_d;
    end
  end

  assign usb_dp_o    = dp_q;
  assign usb_dn_o    = dn_q;
  assign usb_oe_o    = oe_q;
  assign busy_o      = busy_q;
  assign underflow_o = uf_q;

endmodule

// File: tb/tb_usb_fs_line_tx.sv
// ---------------------------------------------------------------------------
// tb_usb_fs_line_tx
//
// Drives byte streams into usb_fs_line_tx and compares the per-cycle line
// output {underflow, busy, oe, dp, dn} against a trace built from the USB
// line rules: SYNC bits, LSB-first data, stuff after six ones, NRZI, EOP.
// ---------------------------------------------------------------------------
module tb_usb_fs_line_tx;

  localparam int BIT_CLKS = 4;
  localparam logic [4:0] IDLE_OBS = 5'b00010;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] tx_data_i = 8'h00;
  logic       tx_valid_i = 1'b0;
  logic       tx_last_i = 1'b0;
  logic       tx_ready_o;
  logic       usb_dp_o;
  logic       usb_dn_o;
  logic       usb_oe_o;
  logic       busy_o;
  logic       underflow_o;

  int checks = 0;
  int errors = 0;

  // Stream entries are {last, data}; a stream ending on a non-last byte
  // leaves the transmitter without data -> underflow.
  logic [8:0] stream_q[$];
  logic [4:0] exp_q[$];

  usb_fs_line_tx #(.BitClks(BIT_CLKS)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .tx_data_i   (tx_data_i),
    .tx_valid_i  (tx_valid_i),
    .tx_last_i   (tx_last_i),
    .tx_ready_o  (tx_ready_o),
    .usb_dp_o    (usb_dp_o),
    .usb_dn_o    (usb_dn_o),
    .usb_oe_o    (usb_oe_o),
    .busy_o      (busy_o),
    .underflow_o (underflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: bit list per packet -> line symbols -> per-cycle trace.
  task automatic build_expected(output int n_underflow, output int n_ready);
    int n, i, ones, eop_start;
    bit uf, line_j;
    bit bits[$];
    logic [1:0] sym[$];
    exp_q.delete();
    exp_q.push_back(IDLE_OBS);
    n = stream_q.size();
    i = 0;
    n_underflow = 0;
    n_ready = 0;
    while (i < n) begin
      bits.delete();
      for (int k = 0; k < 7; k++) bits.push_back(1'b0);
      bits.push_back(1'b1);
      uf = 1'b1;
      while (i < n) begin
        for (int b = 0; b < 8; b++) bits.push_back(stream_q[i][b]);
        n_ready++;
        i++;
        if (stream_q[i-1][8]) begin
          uf = 1'b0;
          break;
        end
      end
      if (uf) begin
        n_underflow++;
        n_ready++;
      end
      sym.delete();
      line_j = 1'b1;
      ones = 0;
      foreach (bits[k]) begin
        if (!bits[k]) line_j = !line_j;
        sym.push_back({line_j, !line_j});
        ones = bits[k] ? ones + 1 : 0;
        if (ones == 6) begin
          line_j = !line_j;
          sym.push_back({line_j, !line_j});
          ones = 0;
        end
      end
      eop_start = sym.size();
      sym.push_back(2'b00);
      sym.push_back(2'b00);
      sym.push_back(2'b10);
      foreach (sym[k]) begin
        for (int c = 0; c < BIT_CLKS; c++) begin
          exp_q.push_back({(uf && k == eop_start && c == 0) ? 1'b1 : 1'b0, 1'b1, 1'b1, sym[k]});
        end
      end
      exp_q.push_back(IDLE_OBS);
    end
    for (int k = 0; k < 3; k++) exp_q.push_back(IDLE_OBS);
  endtask

  // Runs the stream in stream_q for exactly the model's trace length.
  task automatic run_stream(input string name, output int oe_cycles, output int uf_cycles);
    int n_uf, n_rdy, idx, rdy_cnt, first_bad;
    logic [4:0] obs, bad_obs, bad_exp;
    build_expected(n_uf, n_rdy);
    idx = 0;
    rdy_cnt = 0;
    first_bad = -1;
    bad_obs = '0;
    bad_exp = '0;
    oe_cycles = 0;
    uf_cycles = 0;
    for (int cyc = 0; cyc < exp_q.size(); cyc++) begin
      @(negedge clk_i);
      obs = {underflow_o, busy_o, usb_oe_o, usb_dp_o, usb_dn_o};
      if (obs !== exp_q[cyc] && first_bad < 0) begin
        first_bad = cyc;
        bad_obs = obs;
        bad_exp = exp_q[cyc];
      end
      if (usb_oe_o === 1'b1) oe_cycles++;
      if (underflow_o === 1'b1) uf_cycles++;
      if (idx < stream_q.size()) begin
        tx_valid_i = 1'b1;
        {tx_last_i, tx_data_i} = stream_q[idx];
      end else begin
        tx_valid_i = 1'b0;
        tx_last_i = 1'b0;
        tx_data_i = 8'($urandom);
      end
      #1;
      if (tx_ready_o === 1'b1) rdy_cnt++;
      if (tx_valid_i && tx_ready_o === 1'b1) idx++;
    end
    tx_valid_i = 1'b0;
    tx_last_i = 1'b0;

    checks++;
    if (first_bad >= 0) begin
      errors++;
      $display("FAIL %s trace: cycle %0d got {uf,busy,oe,dp,dn}=%b expected %b", name, first_bad, bad_obs, bad_exp);
    end
    checks++;
    if (rdy_cnt !== n_rdy) begin
      errors++;
      $display("FAIL %s ready_cycles: got %0d expected %0d", name, rdy_cnt, n_rdy);
    end
    checks++;
    if (idx !== stream_q.size()) begin
      errors++;
      $display("FAIL %s accepted_bytes: got %0d expected %0d", name, idx, stream_q.size());
    end
    checks++;
    if (uf_cycles !== n_uf) begin
      errors++;
      $display("FAIL %s underflow_pulses: got %0d expected %0d", name, uf_cycles, n_uf);
    end
    $display("stream %s: bytes %0d oe_cycles %0d underflows %0d ready %0d", name, stream_q.size(), oe_cycles, uf_cycles, rdy_cnt);
  endtask

  task automatic check_oe(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s oe_cycles: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    rst_ni = 1'b0;
    tx_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    obs = {usb_dp_o, usb_dn_o, usb_oe_o, busy_o, underflow_o};
    checks++;
    if (obs !== 5'b10000) begin
      errors++;
      $display("FAIL reset_outputs: got {dp,dn,oe,busy,uf}=%b expected 10000", obs);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    #1;
    checks++;
    if (tx_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready_low: got %b expected 0", tx_ready_o);
    end
    tx_valid_i = 1'b1;
    #1;
    checks++;
    if (tx_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready_follows_valid: got %b expected 1", tx_ready_o);
    end
    tx_valid_i = 1'b0;
    $display("reset: outputs %b", obs);
  endtask

  task automatic test_single_byte();
    int oe, ufc;
    stream_q.delete();
    stream_q.push_back({1'b1, 8'h69});
    run_stream("single_69", oe, ufc);
    check_oe("single_69", oe, 76);
  endtask

  task automatic test_stuff_before_eop();
    int oe, ufc;
    stream_q.delete();
    stream_q.push_back({1'b1, 8'hFC});
    run_stream("stuff_fc", oe, ufc);
    check_oe("stuff_fc", oe, 80);
  endtask

  task automatic test_stuff_run();
    int oe, ufc;
    stream_q.delete();
    stream_q.push_back({1'b0, 8'hFF});
    stream_q.push_back({1'b1, 8'hFF});
    run_stream("stuff_ffff", oe, ufc);
    check_oe("stuff_ffff", oe, 116);
  endtask

  task automatic test_underflow();
    int oe, ufc;
    stream_q.delete();
    stream_q.push_back({1'b0, 8'h2D});
    run_stream("underflow_2d", oe, ufc);
    check_oe("underflow_2d", oe, 76);
    checks++;
    if (ufc !== 1) begin
      errors++;
      $display("FAIL underflow_once: got %0d expected 1", ufc);
    end
  endtask

  task automatic test_back_to_back();
    int oe, ufc;
    stream_q.delete();
    stream_q.push_back({1'b1, 8'h69});
    stream_q.push_back({1'b0, 8'hC3});
    stream_q.push_back({1'b1, 8'h01});
    run_stream("back_to_back", oe, ufc);
    check_oe("back_to_back", oe, 76 + 108);
  endtask

  task automatic test_reset_mid();
    int oe, ufc;
    logic [4:0] obs;
    @(negedge clk_i);
    tx_valid_i = 1'b1;
    tx_data_i = 8'h69;
    tx_last_i = 1'b1;
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    tx_last_i = 1'b0;
    repeat (45) @(negedge clk_i);
    checks++;
    if (usb_oe_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_packet_active: got oe=%b busy=%b expected 1 1", usb_oe_o, busy_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    obs = {usb_dp_o, usb_dn_o, usb_oe_o, busy_o, underflow_o};
    checks++;
    if (obs !== 5'b10000) begin
      errors++;
      $display("FAIL async_reset: got {dp,dn,oe,busy,uf}=%b expected 10000", obs);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    $display("reset_mid: outputs during reset %b", obs);
    stream_q.delete();
    stream_q.push_back({1'b1, 8'h69});
    run_stream("after_reset_69", oe, ufc);
    check_oe("after_reset_69", oe, 76);
  endtask

  task automatic test_random();
    int oe, ufc, npk, nby;
    logic [7:0] d;
    logic [8:0] tail;
    for (int it = 0; it < 8; it++) begin
      stream_q.delete();
      npk = $urandom_range(1, 2);
      for (int p = 0; p < npk; p++) begin
        nby = $urandom_range(1, 3);
        for (int b = 0; b < nby; b++) begin
          d = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
          stream_q.push_back({(b == nby - 1) ? 1'b1 : 1'b0, d});
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        tail = stream_q.pop_back();
        tail[8] = 1'b0;
        stream_q.push_back(tail);
      end
      run_stream($sformatf("random%0d", it), oe, ufc);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_stuff_before_eop();
    test_stuff_run();
    test_underflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
